ch_buffer_sequencer: RTL and testbench

- Parametrised per-channel fast-buffer sequencer, successor to the fixed 4+1-buffer channel controller.
- Drives N_BUF fast buffer enables plus one slow buffer enable, advancing by a programmable group size on each qualified discriminator trigger.
- Captures a timestamp per trigger, raises STOP_REQUEST to the chip-level trigger-out OR, and exposes timestamps and trigger count for SPI readout.
- Fully synchronous to FCLK, unlike the edge-triggered predecessor.

---
 rtl/ch_buffer_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_ch_buffer_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ch_buffer_sequencer.sv
// Per-channel fast-buffer sequencer: walks N_BUF active-low fast-buffer enables in groups on each
// qualified discriminator trigger and captures a timestamp per trigger. Optional: CH_DISC_GLITCH_FILT_EN.
`timescale 1ns/1ps

module ch_buffer_sequencer #(
    parameter int N_BUF = 4,
    parameter int TS_W  = 10,
    parameter int DLY_W = 5,
    localparam int CNT_W = $clog2(N_BUF) + 1,
    localparam int GL_W  = $clog2(N_BUF) + 1,
    localparam int RD_W  = (N_BUF > 1) ? $clog2(N_BUF) : 1
) (
    input  logic              FCLK,
    input  logic              RSTB,
    input  logic              INST_START,
    input  logic              INST_STOP,
    input  logic              INST_READOUT,
    input  logic              DISCRIMINATOR_OUTPUT,
    input  logic              DISCRIMINATOR_POLARITY,
    input  logic [GL_W-1:0]   GROUP_LOG2,
    input  logic [DLY_W-1:0]  TRIG_DELAY,
    input  logic [TS_W-1:0]   TSTAMP,
    input  logic [RD_W-1:0]   RD_SEL,
    output logic [N_BUF-1:0]  TRIG_N,
    output logic              TRIG_SLOW_N,
    output logic              STOP_REQUEST,
    output logic [CNT_W-1:0]  TRIGGER_CNT,
    output logic [TS_W-1:0]   RD_TSTAMP,
    output logic [2:0]        STATE
);

    localparam int LOG2N = $clog2(N_BUF);
    localparam int CW1   = CNT_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLING = 3'd1,
        ST_TAIL     = 3'd2,
        ST_STOPPED  = 3'd3,
        ST_READOUT  = 3'd4
    } state_t;

    state_t state, state_nx;

    logic              sync0, sync1;
    logic              pol, pol_d;
    logic              qual, qual_r;
    logic              busy;
    logic [DLY_W-1:0]  dly_cnt;
    logic              fire;
    logic              take_fire;

    logic [GL_W-1:0]   g_log;
    logic [CNT_W-1:0]  g_size;
    logic [CNT_W-1:0]  base;
    logic [CNT_W-1:0]  base_nx;
    logic [CW1-1:0]    span_lo;
    logic [CW1-1:0]    span_hi;
    logic [CNT_W-1:0]  cnt;
    logic              stop_req;
    logic [TS_W-1:0]   ts [N_BUF];
    logic [TS_W-1:0]   rd_val;
    logic [TS_W-1:0]   rd_tstamp;

    assign pol = sync1 ^ ~DISCRIMINATOR_POLARITY;

`ifdef CH_DISC_GLITCH_FILT_EN
    logic pol_d2;
    // Needs two consecutive active samples, so single-cycle glitches never qualify.
    assign qual = pol & pol_d & ~pol_d2;
`else
    assign qual = pol & ~pol_d;
`endif

    // Zero delay fires straight from qual_r; otherwise the counter fires as it reaches 1.
    assign fire = busy ? (dly_cnt == DLY_W'(1)) : (qual_r && (TRIG_DELAY == '0));

    always_ff @(posedge FCLK) begin
        if (!RSTB) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            pol_d   <= 1'b0;
`ifdef CH_DISC_GLITCH_FILT_EN
            pol_d2  <= 1'b0;
`endif
            qual_r  <= 1'b0;
            busy    <= 1'b0;
            dly_cnt <= '0;
        end else begin
            sync0  <= DISCRIMINATOR_OUTPUT;
            sync1  <= sync0;
            pol_d  <= pol;
`ifdef CH_DISC_GLITCH_FILT_EN
            pol_d2 <= pol_d;
`endif
            qual_r <= qual;
            if (INST_START) begin
                busy    <= 1'b0;
                dly_cnt <= '0;
            end else if (busy) begin
                if (dly_cnt == DLY_W'(1)) begin
                    busy <= 1'b0;
                end
                dly_cnt <= dly_cnt - DLY_W'(1);
            end else if (qual_r && (TRIG_DELAY != '0)) begin
                busy    <= 1'b1;
                dly_cnt <= TRIG_DELAY;
            end
        end
    end

    assign g_size  = CNT_W'(1) << g_log;
    assign base_nx = base + g_size;
    assign span_lo = {1'b0, base};
    assign span_hi = {1'b0, base} + {1'b0, g_size};

    always_ff @(posedge FCLK) begin
        if (!RSTB) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        take_fire   = 1'b0;
        TRIG_N      = '1;
        TRIG_SLOW_N = 1'b1;

        if (INST_START) begin
            state_nx = ST_SAMPLING;
        end else if (INST_STOP && ((state == ST_SAMPLING) || (state == ST_TAIL))) begin
            state_nx = ST_STOPPED;
        end else if (INST_READOUT && (state != ST_IDLE)) begin
            state_nx = ST_READOUT;
        end else if (fire && (state == ST_SAMPLING)) begin
            take_fire = 1'b1;
            if (base_nx >= CNT_W'(N_BUF)) begin
                state_nx = ST_TAIL;
            end
        end

        case (state)
            ST_SAMPLING: begin
                TRIG_SLOW_N = 1'b0;
                for (int unsigned i = 0; i < N_BUF; i++) begin
                    if ((CW1'(i) >= span_lo) && (CW1'(i) < span_hi)) begin
                        TRIG_N[i] = 1'b0;
                    end
                end
            end
            ST_TAIL: begin
                TRIG_SLOW_N = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < N_BUF; i++) begin
            if (RD_SEL == RD_W'(i)) begin
                rd_val = ts[i];
            end
        end
    end

    always_ff @(posedge FCLK) begin
        if (!RSTB) begin
            g_log     <= '0;
            base      <= '0;
            cnt       <= '0;
            stop_req  <= 1'b0;
            rd_tstamp <= '0;
            for (int unsigned i = 0; i < N_BUF; i++) begin
                ts[i] <= '0;
            end
        end else begin
            if (INST_START) begin
                g_log    <= (GROUP_LOG2 > GL_W'(LOG2N)) ? GL_W'(LOG2N) : GROUP_LOG2;
                base     <= '0;
                cnt      <= '0;
                stop_req <= 1'b0;
                for (int unsigned i = 0; i < N_BUF; i++) begin
                    ts[i] <= '0;
                end
            end else if (take_fire) begin
                base     <= base_nx;
                cnt      <= cnt + CNT_W'(1);
                stop_req <= 1'b1;
                for (int unsigned i = 0; i < N_BUF; i++) begin
                    if (cnt == CNT_W'(i)) begin
                        ts[i] <= TSTAMP;
                    end
                end
            end
            // Keyed on the next state so the value is exactly 0 in every cycle spent outside READOUT.
            rd_tstamp <= (state_nx == ST_READOUT) ? rd_val : '0;
        end
    end

    assign STOP_REQUEST = stop_req;
    assign TRIGGER_CNT  = cnt;
    assign RD_TSTAMP    = rd_tstamp;
    assign STATE        = state;

endmodule

// File: tb/tb_ch_buffer_sequencer.sv
// Scoreboard bench for ch_buffer_sequencer: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them. Honours CH_DISC_GLITCH_FILT_EN.
`timescale 1ns/1ps

module tb_ch_buffer_sequencer;

    localparam int N_BUF = 4;
    localparam int TS_W  = 10;
    localparam int DLY_W = 5;
    localparam int CNT_W = 3;
    localparam int GL_W  = 3;
    localparam int RD_W  = 2;

`ifdef CH_DISC_GLITCH_FILT_EN
    localparam int PLEN = 2;
    localparam int LAT  = 5;
`else
    localparam int PLEN = 1;
    localparam int LAT  = 4;
`endif

    localparam int K_TN   = 0;
    localparam int K_SLOW = 1;
    localparam int K_STOP = 2;
    localparam int K_CNT  = 3;
    localparam int K_RD   = 4;
    localparam int K_ST   = 5;

    logic              FCLK;
    logic              RSTB;
    logic              INST_START;
    logic              INST_STOP;
    logic              INST_READOUT;
    logic              DISCRIMINATOR_OUTPUT;
    logic              DISCRIMINATOR_POLARITY;
    logic [GL_W-1:0]   GROUP_LOG2;
    logic [DLY_W-1:0]  TRIG_DELAY;
    logic [TS_W-1:0]   TSTAMP;
    logic [RD_W-1:0]   RD_SEL;
    logic [N_BUF-1:0]  TRIG_N;
    logic              TRIG_SLOW_N;
    logic              STOP_REQUEST;
    logic [CNT_W-1:0]  TRIGGER_CNT;
    logic [TS_W-1:0]   RD_TSTAMP;
    logic [2:0]        STATE;

    ch_buffer_sequencer #(
        .N_BUF (N_BUF),
        .TS_W  (TS_W),
        .DLY_W (DLY_W)
    ) dut (
        .FCLK                   (FCLK),
        .RSTB                   (RSTB),
        .INST_START             (INST_START),
        .INST_STOP              (INST_STOP),
        .INST_READOUT           (INST_READOUT),
        .DISCRIMINATOR_OUTPUT   (DISCRIMINATOR_OUTPUT),
        .DISCRIMINATOR_POLARITY (DISCRIMINATOR_POLARITY),
        .GROUP_LOG2             (GROUP_LOG2),
        .TRIG_DELAY             (TRIG_DELAY),
        .TSTAMP                 (TSTAMP),
        .RD_SEL                 (RD_SEL),
        .TRIG_N                 (TRIG_N),
        .TRIG_SLOW_N            (TRIG_SLOW_N),
        .STOP_REQUEST           (STOP_REQUEST),
        .TRIGGER_CNT            (TRIGGER_CNT),
        .RD_TSTAMP              (RD_TSTAMP),
        .STATE                  (STATE)
    );

    typedef struct {
        int unsigned at;
        int          kind;
        int unsigned exp;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          tag = 0;
    int unsigned ts_tab [4] = '{10, 20, 30, 40};

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    always @(posedge FCLK) cyc <= cyc + 1;

    function automatic int unsigned actual(input int k);
        case (k)
            K_TN:    return 32'(TRIG_N);
            K_SLOW:  return 32'(TRIG_SLOW_N);
            K_STOP:  return 32'(STOP_REQUEST);
            K_CNT:   return 32'(TRIGGER_CNT);
            K_RD:    return 32'(RD_TSTAMP);
            default: return 32'(STATE);
        endcase
    endfunction

    function automatic string kname(input int k);
        case (k)
            K_TN:    return "trig_n";
            K_SLOW:  return "trig_slow_n";
            K_STOP:  return "stop_request";
            K_CNT:   return "trigger_cnt";
            K_RD:    return "rd_tstamp";
            default: return "state";
        endcase
    endfunction

    always @(negedge FCLK) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.at != cyc || actual(mon_e.kind) != mon_e.exp) begin
                n_fail++;
                $display("FAIL %s step%0d cyc=%0d due=%0d actual=0x%0h required=0x%0h",
                         kname(mon_e.kind), mon_e.tag, cyc, mon_e.at,
                         actual(mon_e.kind), mon_e.exp);
            end
        end
    end

    task automatic expect_at(input int unsigned d, input int k, input int unsigned v);
        exp_t e;
        int   idx;
        e.at   = cyc + d;
        e.kind = k;
        e.exp  = v;
        e.tag  = tag;
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > e.at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FCLK);
            #1;
        end
    endtask

    task automatic start_run();
        INST_START = 1'b1;
        tick(1);
        INST_START = 1'b0;
    endtask

    // One discriminator pulse in the active direction; checks the count one cycle before
    // the expected fire and the full output set on the fire cycle.
    task automatic fire_pulse(input int unsigned ts_val, input int unsigned exp_tn,
                              input int unsigned prev_cnt, input int unsigned exp_cnt,
                              input int unsigned exp_st);
        tag++;
        TSTAMP = TS_W'(ts_val);
        expect_at(LAT - 1, K_CNT, prev_cnt);
        expect_at(LAT, K_TN, exp_tn);
        expect_at(LAT, K_CNT, exp_cnt);
        expect_at(LAT, K_ST, exp_st);
        DISCRIMINATOR_OUTPUT = DISCRIMINATOR_POLARITY;
        tick(PLEN);
        DISCRIMINATOR_OUTPUT = ~DISCRIMINATOR_POLARITY;
        tick(LAT + 2);
    endtask

    initial begin
        RSTB                   = 1'b0;
        INST_START             = 1'b0;
        INST_STOP              = 1'b0;
        INST_READOUT           = 1'b0;
        DISCRIMINATOR_OUTPUT   = 1'b0;
        DISCRIMINATOR_POLARITY = 1'b1;
        GROUP_LOG2             = '0;
        TRIG_DELAY             = '0;
        TSTAMP                 = '0;
        RD_SEL                 = '0;

        // reset / idle
        tick(2);
        RSTB = 1'b1;
        tag = 1;
        expect_at(0, K_TN, 'hF);
        expect_at(0, K_SLOW, 1);
        expect_at(0, K_STOP, 0);
        expect_at(0, K_ST, 0);
        expect_at(0, K_CNT, 0);
        expect_at(0, K_RD, 0);
        tick(2);

        // one buffer per event
        tag = 10;
        GROUP_LOG2 = 3'd0;
        start_run();
        expect_at(0, K_ST, 1);
        expect_at(0, K_TN, 'hE);
        expect_at(0, K_SLOW, 0);
        expect_at(0, K_STOP, 0);
        fire_pulse(10, 'hD, 0, 1, 1);
        expect_at(0, K_STOP, 1);
        fire_pulse(20, 'hB, 1, 2, 1);
        fire_pulse(30, 'h7, 2, 3, 1);
        fire_pulse(40, 'hF, 3, 4, 2);
        expect_at(0, K_SLOW, 0);
        fire_pulse(50, 'hF, 4, 4, 2);

        // timestamp readout
        tag = 20;
        RD_SEL = 2'd0;
        INST_READOUT = 1'b1;
        tick(1);
        INST_READOUT = 1'b0;
        expect_at(0, K_ST, 4);
        expect_at(0, K_TN, 'hF);
        expect_at(0, K_SLOW, 1);
        expect_at(1, K_RD, ts_tab[0]);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            RD_SEL = RD_W'(i);
            expect_at(1, K_RD, ts_tab[i]);
        end
        tick(2);

        // group of two, then clamped group
        tag = 30;
        GROUP_LOG2 = 3'd1;
        start_run();
        expect_at(0, K_TN, 'hC);
        expect_at(0, K_CNT, 0);
        expect_at(0, K_ST, 1);
        expect_at(0, K_RD, 0);
        fire_pulse(60, 'h3, 0, 1, 1);
        fire_pulse(70, 'hF, 1, 2, 2);
        tag = 40;
        GROUP_LOG2 = 3'd3;
        start_run();
        expect_at(0, K_TN, 'h0);
        GROUP_LOG2 = 3'd0;
        fire_pulse(80, 'hF, 0, 1, 2);

        // delay and holdoff
        tag = 50;
        GROUP_LOG2 = 3'd0;
        TRIG_DELAY = 5'd5;
        start_run();
        expect_at(0, K_TN, 'hE);
        TSTAMP = 10'd90;
        expect_at(LAT + 4, K_TN, 'hE);
        expect_at(LAT + 5, K_TN, 'hD);
        expect_at(LAT + 5, K_CNT, 1);
        expect_at(LAT + 20, K_CNT, 1);
        expect_at(LAT + 20, K_TN, 'hD);
        DISCRIMINATOR_OUTPUT = 1'b1;
        tick(PLEN);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick(4 - PLEN);
        DISCRIMINATOR_OUTPUT = 1'b1;
        tick(PLEN);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick(LAT + 22);
        TRIG_DELAY = 5'd0;

        // stop wins over a coincident fire
        tag = 60;
        start_run();
        fire_pulse(111, 'hD, 0, 1, 1);
        tag = 61;
        TSTAMP = 10'd222;
        expect_at(LAT, K_ST, 3);
        expect_at(LAT, K_CNT, 1);
        expect_at(LAT, K_TN, 'hF);
        expect_at(LAT, K_SLOW, 1);
        expect_at(LAT, K_STOP, 1);
        DISCRIMINATOR_OUTPUT = 1'b1;
        tick(PLEN);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick(LAT - 1 - PLEN);
        INST_STOP = 1'b1;
        tick(1);
        INST_STOP = 1'b0;
        tick(3);
        tag = 62;
        RD_SEL = 2'd0;
        INST_READOUT = 1'b1;
        tick(1);
        INST_READOUT = 1'b0;
        expect_at(0, K_ST, 4);
        expect_at(1, K_RD, 111);
        tick(1);
        RD_SEL = 2'd1;
        expect_at(1, K_RD, 0);
        tick(2);
        tag = 63;
        start_run();
        expect_at(0, K_CNT, 0);
        expect_at(0, K_STOP, 0);
        expect_at(0, K_ST, 1);
        expect_at(0, K_RD, 0);
        expect_at(0, K_TN, 'hE);
        tick(2);

        // active-low polarity
        tag = 70;
        INST_STOP = 1'b1;
        tick(1);
        INST_STOP = 1'b0;
        expect_at(0, K_ST, 3);
        DISCRIMINATOR_POLARITY = 1'b0;
        DISCRIMINATOR_OUTPUT   = 1'b1;
        tick(8);
        start_run();
        expect_at(0, K_TN, 'hE);
        expect_at(0, K_CNT, 0);
        fire_pulse(123, 'hD, 0, 1, 1);

`ifdef CH_DISC_GLITCH_FILT_EN
        // a single-cycle glitch must not fire
        tag = 80;
        expect_at(10, K_CNT, 1);
        expect_at(10, K_TN, 'hD);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick(1);
        DISCRIMINATOR_OUTPUT = 1'b1;
        tick(12);
`endif

        // reset while a trigger is in flight
        tag = 90;
        expect_at(LAT + 1, K_ST, 0);
        expect_at(LAT + 1, K_CNT, 0);
        expect_at(LAT + 1, K_STOP, 0);
        expect_at(LAT + 1, K_TN, 'hF);
        DISCRIMINATOR_OUTPUT = 1'b0;
        tick(PLEN);
        DISCRIMINATOR_OUTPUT = 1'b1;
        RSTB = 1'b0;
        tick(1);
        RSTB = 1'b1;
        tick(LAT + 3);

        for (int i = 0; i < 200 && sb.size() > 0; i++) begin
            tick(1);
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
